rob_retire: RTL and testbench
=============================

Name: rob_retire

Overview:
- Circular reorder buffer sitting directly upstream of the architectural register file.
- Accepts one dispatched instruction per cycle and records completion results from two writeback ports.
- Retires up to two completed instructions per cycle, in program order.
- Drives the register file's dual write ports (retire1/write_addr1/write_data1, retire2/write_addr2/write_data2).

Parameters:
DEPTH, 16, number of entries (power of two)
TAG_W, 4, log2(DEPTH); width of an entry tag
PREG_W, 6, physical register index width
AREG_W, 5, architectural register index width
DATA_W, 32, result data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush; empties the buffer
alloc_valid  in  1  dispatch request
alloc_ready  out  1  buffer can accept (count < DEPTH)
alloc_has_dest  in  1  instruction writes a register
alloc_areg  in  AREG_W  architectural destination
alloc_preg  in  PREG_W  physical destination
alloc_tag  out  TAG_W  entry index granted to the current request (tail pointer)
wb0_valid, wb1_valid  in  1  completion strobes
wb0_tag, wb1_tag  in  TAG_W  completing entry
wb0_data, wb1_data  in  DATA_W  result
retire1, retire2  out  1  register file write enables
write_addr1, write_addr2  out  PREG_W  physical register written
write_data1, write_data2  out  DATA_W  retired result
retire_areg1, retire_areg2  out  AREG_W  architectural register of the retiring slot
retired_cnt  out  2  entries freed last cycle (0..2), including entries with no destination
count  out  TAG_W+1  occupied entries

Behaviour:
- Per-entry state: valid, done, has_dest, areg, preg, data.
- head/tail pointers are TAG_W+1 bits; the extra bit is a wrap bit.
  - empty when head==tail; full when the index bits match and the wrap bits differ.
  - count = tail-head, modulo 2^(TAG_W+1).
- Reset (async, rst=1): all valid/done cleared, head=tail=0, count=0.
  - retire1/2=0, retired_cnt=0, write_addr*/write_data*/retire_areg*=0.
  - alloc_ready=1 after reset.
- Allocation:
  - Occurs when alloc_valid & alloc_ready.
  - Entry[tail] gets valid=1, done=0 and the fields; tail increments and wraps at DEPTH.
  - alloc_tag = tail index, combinational.
  - alloc_ready is decoded from registered count only; retirement in the same cycle does not raise it.
- Writeback:
  - wbN_valid to a valid entry sets done=1 and stores data.
  - Writeback to an invalid entry is ignored.
  - Both ports on the same tag: wb0 wins.
  - Writeback and allocation of the same index in one cycle: allocation wins (done=0).
- Retire selection, evaluated on registered state at each edge:
  - slot1 = head entry, if valid & done.
  - slot2 = head+1 entry (wrapping), if slot1 retires and head+1 is valid & done.
  - Strictly in order: slot2 never retires when slot1 does not.
- Retire outputs: registered, one-cycle latency after the edge that frees the entry.
  - retireN = selected & has_dest.
  - write_addrN = preg, write_dataN = data, retire_areg = areg.
  - When retireN=0, the data/addr outputs hold 0.
- Freeing: freed entries get valid=0; head advances by retired_cnt.
- No bypass: an entry completed at edge N is first eligible for retirement at edge N+1; it appears on the outputs after edge N+1.
- Same-edge events: allocation, two writebacks and two retirements may all occur in one edge.
  - count_next = count + alloc - retired.
- Flush (sync) has priority over alloc, writeback and retire.
  - Clears all valid bits, head=tail=0.
  - Retire outputs and retired_cnt are 0 on the following cycle.
  - Retire outputs registered before the flush edge remain visible until that edge.
- Reset mid-operation: state and outputs clear immediately, regardless of clk.
- Single-entry case: only slot1 retires; slot2 is never selected from an empty head+1.

Decomposition:
- Shared package holds:
  - DEPTH/TAG_W/PREG_W/AREG_W/DATA_W constants.
  - A rob_entry typedef {valid, done, has_dest, areg, preg, data}, so rename, issue and the register file share widths.
- One natural sub-module: rob_ptr, a wrapping TAG_W+1-bit pointer with increment-by-0/1/2. It is instantiated for head and tail and supplies full/empty/count decoding.
- Entry storage and retire selection stay in rob_retire.

Test Plan:
- Reset then single alloc (has_dest=1, areg=10, preg=33):
  - alloc_tag=0.
  - wb0 tag0 data 0xDEADBEEF.
  - Two cycles later: retire1=1, write_addr1=33, write_data1=0xDEADBEEF, retire_areg1=10, retired_cnt=1, retire2=0.
- Fill 16 entries:
  - alloc_ready=0 with count=16; a 17th alloc_valid is ignored and tail is unchanged.
  - Complete tags 0 and 1 -> dual retire (retired_cnt=2); alloc_ready=1 one cycle later.
- Out-of-order completion: complete tag2 before tag1 -> no retire; after tag1 completes -> tags 1 and 2 retire in the same cycle, in order.
- Same-tag writeback: wb0 and wb1 both to tag3 with 0x11/0x22 -> retired data is 0x11.
  - An entry with has_dest=0 retires with retire1=0 and retired_cnt=1.
- Wrap-around: run 40 alloc/complete/retire cycles; the head crosses index 15->0 while retiring a pair at 15/0; addresses and data stay correct.
- Flush with 5 entries, 2 completed:
  - count=0 next cycle, no retire asserted; later allocation starts at tag 0.
  - rst pulse mid-retire clears retire1/retire2 asynchronously.

Source files
------------

// File: rtl/rob_retire_pkg.sv
// Shared widths and the reorder-buffer entry layout used by rename, issue and
// the register file.
package rob_retire_pkg;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 4;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  function automatic logic [1:0] retire_count(input logic s1, input logic s2);
    return {1'b0, s1} + {1'b0, s2};
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping circular-buffer pointer with a wrap bit, stepping by 0/1/2, plus
// occupancy/full/empty decode against a peer pointer.
module rob_ptr #(
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [1:0]     inc,
  input  logic [TAG_W:0] peer,
  output logic [TAG_W:0] ptr,
  output logic [TAG_W:0] occ,
  output logic           full,
  output logic           empty
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (clr) ptr <= '0;
    else          ptr <= ptr + {{(TAG_W-1){1'b0}}, inc};
  end

  // Same index with opposite wrap bits means the pointers are a full lap apart.
  assign occ   = ptr - peer;
  assign full  = (ptr[TAG_W-1:0] == peer[TAG_W-1:0]) && (ptr[TAG_W] != peer[TAG_W]);
  assign empty = (ptr == peer);

endmodule

// File: rtl/rob_retire.sv
// Circular reorder buffer: one dispatch per cycle, two writeback ports, and
// in-order retirement of up to two entries per cycle into the register file.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_has_dest,
  input  logic [AREG_W-1:0] alloc_areg,
  input  logic [PREG_W-1:0] alloc_preg,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb0_valid,
  input  logic [TAG_W-1:0]  wb0_tag,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  input  logic [TAG_W-1:0]  wb1_tag,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              retire1,
  output logic [PREG_W-1:0] write_addr1,
  output logic [DATA_W-1:0] write_data1,
  output logic [AREG_W-1:0] retire_areg1,
  output logic              retire2,
  output logic [PREG_W-1:0] write_addr2,
  output logic [DATA_W-1:0] write_data2,
  output logic [AREG_W-1:0] retire_areg2,
  output logic [1:0]        retired_cnt,
  output logic [TAG_W:0]    count
);

  logic [TAG_W:0]    head, tail, head_occ, tail_occ;
  logic              head_full, head_empty, tail_full, tail_empty;
  logic [1:0]        ret_n;
  logic              do_alloc, sel1, sel2;
  logic [TAG_W-1:0]  h0, h1, t0;
  logic [DEPTH-1:0]  valid_q, done_q;
  logic              hd_q   [DEPTH];
  logic [AREG_W-1:0] areg_q [DEPTH];
  logic [PREG_W-1:0] preg_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  rob_entry_t        e1, e2;
  logic              unused_dec;

  rob_ptr #(.TAG_W(TAG_W)) u_head (
    .clk(clk), .rst(rst), .clr(flush), .inc(ret_n), .peer(tail),
    .ptr(head), .occ(head_occ), .full(head_full), .empty(head_empty)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk(clk), .rst(rst), .clr(flush), .inc({1'b0, do_alloc}), .peer(head),
    .ptr(tail), .occ(tail_occ), .full(tail_full), .empty(tail_empty)
  );

  assign unused_dec  = ^{head_occ, head_full, tail_empty};
  assign count       = tail_occ;
  assign alloc_ready = ~tail_full;
  assign alloc_tag   = tail[TAG_W-1:0];
  assign t0          = tail[TAG_W-1:0];
  assign h0          = head[TAG_W-1:0];
  assign h1          = h0 + TAG_W'(1);
  assign do_alloc    = alloc_valid & ~tail_full & ~flush;

  assign e1 = '{valid: valid_q[h0], done: done_q[h0], has_dest: hd_q[h0],
                areg: areg_q[h0], preg: preg_q[h0], data: data_q[h0]};
  assign e2 = '{valid: valid_q[h1], done: done_q[h1], has_dest: hd_q[h1],
                areg: areg_q[h1], preg: preg_q[h1], data: data_q[h1]};

  // Selection looks only at registered state, so a same-edge completion waits a cycle.
  assign sel1  = ~head_empty & e1.valid & e1.done;
  assign sel2  = sel1 & e2.valid & e2.done;
  assign ret_n = flush ? 2'd0 : retire_count(sel1, sel2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (wb1_valid && valid_q[wb1_tag]) done_q[wb1_tag] <= 1'b1;
      if (wb0_valid && valid_q[wb0_tag]) done_q[wb0_tag] <= 1'b1;
      if (sel1) begin
        valid_q[h0] <= 1'b0;
        done_q[h0]  <= 1'b0;
      end
      if (sel2) begin
        valid_q[h1] <= 1'b0;
        done_q[h1]  <= 1'b0;
      end
      if (do_alloc) begin
        valid_q[t0] <= 1'b1;
        done_q[t0]  <= 1'b0;
      end
    end
  end

  // Payload carries no reset; valid/done gate every use of it.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      hd_q[t0]   <= alloc_has_dest;
      areg_q[t0] <= alloc_areg;
      preg_q[t0] <= alloc_preg;
    end
    if (wb1_valid && valid_q[wb1_tag]) data_q[wb1_tag] <= wb1_data;
    if (wb0_valid && valid_q[wb0_tag]) data_q[wb0_tag] <= wb0_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      retire1      <= 1'b0;
      write_addr1  <= '0;
      write_data1  <= '0;
      retire_areg1 <= '0;
      retire2      <= 1'b0;
      write_addr2  <= '0;
      write_data2  <= '0;
      retire_areg2 <= '0;
      retired_cnt  <= 2'd0;
    end else begin
      retire1      <= sel1 & e1.has_dest;
      write_addr1  <= (sel1 & e1.has_dest) ? e1.preg : '0;
      write_data1  <= (sel1 & e1.has_dest) ? e1.data : '0;
      retire_areg1 <= (sel1 & e1.has_dest) ? e1.areg : '0;
      retire2      <= sel2 & e2.has_dest;
      write_addr2  <= (sel2 & e2.has_dest) ? e2.preg : '0;
      write_data2  <= (sel2 & e2.has_dest) ? e2.data : '0;
      retire_areg2 <= (sel2 & e2.has_dest) ? e2.areg : '0;
      retired_cnt  <= ret_n;
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Directed and randomized bench for rob_retire against a program-order queue
// model of the buffer.
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic              clk = 1'b0;
  logic              rst, flush, alloc_valid, alloc_ready, alloc_has_dest;
  logic [AREG_W-1:0] alloc_areg;
  logic [PREG_W-1:0] alloc_preg;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb0_valid, wb1_valid;
  logic [TAG_W-1:0]  wb0_tag, wb1_tag;
  logic [DATA_W-1:0] wb0_data, wb1_data;
  logic              retire1, retire2;
  logic [PREG_W-1:0] write_addr1, write_addr2;
  logic [DATA_W-1:0] write_data1, write_data2;
  logic [AREG_W-1:0] retire_areg1, retire_areg2;
  logic [1:0]        retired_cnt;
  logic [TAG_W:0]    count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rob_retire dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_has_dest(alloc_has_dest),
    .alloc_areg(alloc_areg), .alloc_preg(alloc_preg), .alloc_tag(alloc_tag),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data),
    .retire1(retire1), .write_addr1(write_addr1), .write_data1(write_data1), .retire_areg1(retire_areg1),
    .retire2(retire2), .write_addr2(write_addr2), .write_data2(write_data2), .retire_areg2(retire_areg2),
    .retired_cnt(retired_cnt), .count(count)
  );

  // Reference model: instructions in program order, oldest at index 0.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic              hd;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic              done;
    logic [DATA_W-1:0] data;
  } ment_t;

  ment_t             q[$];
  logic [TAG_W-1:0]  ttag;
  logic              e_r1, e_r2;
  logic [PREG_W-1:0] e_wa1, e_wa2;
  logic [DATA_W-1:0] e_wd1, e_wd2;
  logic [AREG_W-1:0] e_ar1, e_ar2;
  logic [1:0]        e_rc;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear_outputs();
    e_r1 = 0; e_wa1 = '0; e_wd1 = '0; e_ar1 = '0;
    e_r2 = 0; e_wa2 = '0; e_wd2 = '0; e_ar2 = '0;
    e_rc = 2'd0;
  endtask

  task automatic model_reset();
    q.delete();
    ttag = '0;
    model_clear_outputs();
  endtask

  task automatic model_edge();
    int sz0;
    int n;
    sz0 = q.size();
    model_clear_outputs();
    if (flush) begin
      q.delete();
      ttag = '0;
      return;
    end
    n = 0;
    if (q.size() > 0 && q[0].done) begin
      n = 1;
      if (q[0].hd) begin
        e_r1 = 1; e_wa1 = q[0].preg; e_wd1 = q[0].data; e_ar1 = q[0].areg;
      end
      if (q.size() > 1 && q[1].done) begin
        n = 2;
        if (q[1].hd) begin
          e_r2 = 1; e_wa2 = q[1].preg; e_wd2 = q[1].data; e_ar2 = q[1].areg;
        end
      end
    end
    e_rc = 2'(n);
    repeat (n) void'(q.pop_front());
    for (int i = 0; i < q.size(); i++) begin
      if (wb1_valid && q[i].tag == wb1_tag) begin q[i].done = 1; q[i].data = wb1_data; end
    end
    for (int i = 0; i < q.size(); i++) begin
      if (wb0_valid && q[i].tag == wb0_tag) begin q[i].done = 1; q[i].data = wb0_data; end
    end
    if (alloc_valid && sz0 < DEPTH) begin
      q.push_back('{tag: ttag, hd: alloc_has_dest, areg: alloc_areg, preg: alloc_preg,
                    done: 1'b0, data: '0});
      ttag = ttag + 1'b1;
    end
  endtask

  task automatic check_all();
    chk("retire1", 32'(retire1), 32'(e_r1));
    chk("retire2", 32'(retire2), 32'(e_r2));
    chk("write_addr1", 32'(write_addr1), 32'(e_wa1));
    chk("write_addr2", 32'(write_addr2), 32'(e_wa2));
    chk("write_data1", write_data1, e_wd1);
    chk("write_data2", write_data2, e_wd2);
    chk("retire_areg1", 32'(retire_areg1), 32'(e_ar1));
    chk("retire_areg2", 32'(retire_areg2), 32'(e_ar2));
    chk("retired_cnt", 32'(retired_cnt), 32'(e_rc));
    chk("count", 32'(count), 32'(q.size()));
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
    chk("alloc_tag", 32'(alloc_tag), 32'(ttag));
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; wb0_valid = 0; wb1_valid = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic pulse_reset();
    rst = 1;
    #1;
    chk("rst_async_retire1", 32'(retire1), 32'd0);
    chk("rst_async_retire2", 32'(retire2), 32'd0);
    chk("rst_async_count", 32'(count), 32'd0);
    model_reset();
    rst = 0;
  endtask

  task automatic wb(input int port, input int tag, input logic [31:0] d);
    if (port == 0) begin wb0_valid = 1; wb0_tag = 4'(tag); wb0_data = d; end
    else           begin wb1_valid = 1; wb1_tag = 4'(tag); wb1_data = d; end
  endtask

  initial begin
    int lim;
    rst = 1;
    idle();
    alloc_has_dest = 0; alloc_areg = '0; alloc_preg = '0;
    wb0_tag = '0; wb1_tag = '0; wb0_data = '0; wb1_data = '0;
    model_reset();
    #3;
    check_all();
    rst = 0;

    // Single instruction through dispatch, completion and retirement.
    alloc_valid = 1; alloc_has_dest = 1; alloc_areg = 5'd10; alloc_preg = 6'd33;
    chk("t1_alloc_tag", 32'(alloc_tag), 32'd0);
    cyc();
    idle(); wb(0, 0, 32'hDEADBEEF);
    cyc();
    idle();
    cyc();
    chk("t1_retire1", 32'(retire1), 32'd1);
    chk("t1_addr1", 32'(write_addr1), 32'd33);
    chk("t1_data1", write_data1, 32'hDEADBEEF);
    chk("t1_areg1", 32'(retire_areg1), 32'd10);
    chk("t1_cnt", 32'(retired_cnt), 32'd1);
    chk("t1_retire2", 32'(retire2), 32'd0);

    // Asynchronous reset while retire1 is asserted.
    #1;
    pulse_reset();

    // Fill all entries; tag 5 carries no destination.
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid = 1; alloc_has_dest = (i != 5);
      alloc_areg = 5'(i + 1); alloc_preg = 6'(i + 32);
      cyc();
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    alloc_areg = 5'd31;
    cyc();
    chk("full_tag_hold", 32'(alloc_tag), 32'd0);
    chk("full_count_hold", 32'(count), 32'd16);
    idle(); wb(0, 0, 32'd100); wb(1, 1, 32'd101);
    cyc();
    idle();
    cyc();
    chk("dual_cnt", 32'(retired_cnt), 32'd2);
    chk("dual_data1", write_data1, 32'd100);
    chk("dual_data2", write_data2, 32'd101);
    chk("dual_ready", 32'(alloc_ready), 32'd1);

    // Younger entry completes first; nothing retires until the head does.
    wb(0, 3, 32'd203);
    cyc();
    idle();
    cyc();
    chk("ooo_hold_cnt", 32'(retired_cnt), 32'd0);
    wb(0, 2, 32'd202);
    cyc();
    idle();
    cyc();
    chk("ooo_cnt", 32'(retired_cnt), 32'd2);
    chk("ooo_addr1", 32'(write_addr1), 32'd34);
    chk("ooo_addr2", 32'(write_addr2), 32'd35);
    chk("ooo_data1", write_data1, 32'd202);
    chk("ooo_data2", write_data2, 32'd203);

    // Both writeback ports on one tag: port 0 wins.
    wb(0, 4, 32'h11); wb(1, 4, 32'h22);
    cyc();
    idle();
    cyc();
    chk("same_tag_data", write_data1, 32'h11);

    // Entry without a destination frees a slot but does not write.
    wb(0, 5, 32'd5);
    cyc();
    idle();
    cyc();
    chk("nodest_retire1", 32'(retire1), 32'd0);
    chk("nodest_cnt", 32'(retired_cnt), 32'd1);

    // Randomized traffic with wrap-around and occasional flushes.
    for (int c = 0; c < 600; c++) begin
      idle();
      alloc_valid = ($urandom_range(0, 3) != 0);
      alloc_has_dest = ($urandom_range(0, 7) != 0);
      alloc_areg = 5'($urandom);
      alloc_preg = 6'($urandom);
      lim = (q.size() < 4) ? q.size() : 4;
      if (lim > 0 && $urandom_range(0, 3) != 0)
        wb(0, int'(q[$urandom_range(0, lim - 1)].tag), $urandom);
      else if ($urandom_range(0, 7) == 0)
        wb(0, int'($urandom_range(0, 15)), $urandom);
      if (lim > 0 && $urandom_range(0, 2) != 0)
        wb(1, int'(q[$urandom_range(0, lim - 1)].tag), $urandom);
      flush = ($urandom_range(0, 79) == 0);
      cyc();
    end
    idle();

    // Flush with five entries, two of them completed.
    #1;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1; alloc_has_dest = 1;
      alloc_areg = 5'(i); alloc_preg = 6'(i + 8);
      cyc();
    end
    idle(); wb(0, 2, 32'd22); wb(1, 3, 32'd33);
    cyc();
    idle(); flush = 1;
    cyc();
    flush = 0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_retire1", 32'(retire1), 32'd0);
    chk("flush_cnt", 32'(retired_cnt), 32'd0);
    chk("flush_tag", 32'(alloc_tag), 32'd0);
    alloc_valid = 1; alloc_has_dest = 1; alloc_areg = 5'd7; alloc_preg = 6'd7;
    cyc();
    idle();
    chk("post_flush_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
